// File: rtl/regfile_sb.sv
// Integer register file with two combinational read ports, one write port,
// a pending-write scoreboard for hazard stalls and a sequential clear engine.
module regfile_sb #(
  parameter int XLEN     = 32,
  parameter int NREGS    = 32,
  parameter int AW       = $clog2(NREGS),
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            reg_write,
  input  logic [AW-1:0]   wr,
  input  logic [XLEN-1:0] wd,
  input  logic [AW-1:0]   rr1,
  input  logic [AW-1:0]   rr2,
  output logic [XLEN-1:0] rd1,
  output logic [XLEN-1:0] rd2,
  input  logic            issue_valid,
  input  logic [AW-1:0]   issue_rd,
  output logic            busy1,
  output logic            busy2,
  input  logic            clr_req,
  output logic            clr_busy,
  output logic            clr_done,
  output logic [0:0]      o_dbg_state
);

  localparam logic [0:0]    S_IDLE   = 1'b0;
  localparam logic [0:0]    S_CLEAR  = 1'b1;
  localparam logic [AW-1:0] LAST_IDX = AW'(NREGS - 1);

  logic [XLEN-1:0] r_regs [NREGS];
  logic [NREGS-1:0] r_pend;
  logic [0:0]       r_state;
  logic [AW-1:0]    r_clr_idx;

  logic w_idle;
  logic w_wr_ok;
  logic w_iss_ok;
  logic w_byp1;
  logic w_byp2;
  logic w_last;

  // Out-of-range indices and the hardwired zero register are treated alike.
  function automatic logic idx_valid(input logic [AW-1:0] idx);
    logic w_in_range;
    logic w_is_zero;
    w_in_range = (32'(idx) < NREGS);
    w_is_zero  = (ZERO_REG != 0) && (idx == '0);
    return w_in_range && !w_is_zero;
  endfunction

  assign w_idle   = (r_state == S_IDLE);
  assign w_last   = (r_clr_idx == LAST_IDX);
  assign w_wr_ok  = w_idle && reg_write && idx_valid(wr);
  assign w_iss_ok = w_idle && issue_valid && idx_valid(issue_rd);
  assign w_byp1   = (BYPASS != 0) && w_wr_ok && (wr == rr1);
  assign w_byp2   = (BYPASS != 0) && w_wr_ok && (wr == rr2);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_clr_idx <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (clr_req) begin
            r_state   <= S_CLEAR;
            r_clr_idx <= '0;
          end
        end
        S_CLEAR: begin
          if (w_last) begin
            r_state   <= S_IDLE;
            r_clr_idx <= '0;
          end else begin
            r_clr_idx <= r_clr_idx + 1'b1;
          end
        end
        default: begin
          r_state   <= S_IDLE;
          r_clr_idx <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREGS; i++) begin
        r_regs[i] <= '0;
      end
    end else if (!w_idle) begin
      r_regs[r_clr_idx] <= '0;
    end else if (w_wr_ok) begin
      r_regs[wr] <= wd;
    end
  end

  // The issue set is applied after the writeback clear so a newer producer
  // to the same register stays pending.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pend <= '0;
    end else if (!w_idle) begin
      r_pend[r_clr_idx] <= 1'b0;
    end else begin
      if (w_wr_ok) begin
        r_pend[wr] <= 1'b0;
      end
      if (w_iss_ok) begin
        r_pend[issue_rd] <= 1'b1;
      end
    end
  end

  always_comb begin
    rd1 = '0;
    if (idx_valid(rr1)) begin
      rd1 = w_byp1 ? wd : r_regs[rr1];
    end
  end

  always_comb begin
    rd2 = '0;
    if (idx_valid(rr2)) begin
      rd2 = w_byp2 ? wd : r_regs[rr2];
    end
  end

  // A clear in flight stalls every operand, valid index or not.
  always_comb begin
    busy1 = 1'b1;
    busy2 = 1'b1;
    if (w_idle) begin
      busy1 = idx_valid(rr1) && r_pend[rr1] && !w_byp1;
      busy2 = idx_valid(rr2) && r_pend[rr2] && !w_byp2;
    end
  end

  assign clr_busy    = !w_idle;
  assign clr_done    = !w_idle && w_last;
  assign o_dbg_state = r_state;

endmodule
